reg_dump_reader: RTL and testbench

- Debug/readback master for the 8x8 register file.
- On a START pulse, drives the file's two asynchronous read-address ports to read the registers in pairs (2k, 2k+1) and captures both read-data buses.
- Streams the 8 bytes out in register order over a VALID/READY byte handshake, tagged with register index.
- Sits beside the CPU datapath and shares the register file's read ports; the control unit grants the ports while BUSY is high.

---
 rtl/reg_dump_reader_if.sv | 30 +++
 rtl/reg_dump_reader.sv | 104 ++++++++++
 tb/tb_reg_dump_reader.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_dump_reader_if.sv
// reg_dump_reader_if
//   Bundles the two buses the dump reader owns:
//   - register-file read port: RD_ADDR1/RD_ADDR2 out, RD_DATA1/RD_DATA2 back
//     (asynchronous read, settles well within one CLK period)
//   - byte stream: DOUT/DOUT_IDX/DOUT_VALID out, DOUT_READY back
//   master : the dump reader
//   slave  : register file + byte sink side
interface reg_dump_reader_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0] RD_ADDR1;
  logic [ADDR_WIDTH-1:0] RD_ADDR2;
  logic [DATA_WIDTH-1:0] RD_DATA1;
  logic [DATA_WIDTH-1:0] RD_DATA2;
  logic [DATA_WIDTH-1:0] DOUT;
  logic [ADDR_WIDTH-1:0] DOUT_IDX;
  logic                  DOUT_VALID;
  logic                  DOUT_READY;

  modport master (
    output RD_ADDR1, RD_ADDR2, DOUT, DOUT_IDX, DOUT_VALID,
    input  RD_DATA1, RD_DATA2, DOUT_READY
  );

  modport slave (
    input  RD_ADDR1, RD_ADDR2, DOUT, DOUT_IDX, DOUT_VALID,
    output RD_DATA1, RD_DATA2, DOUT_READY
  );
endinterface

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug readback master for the 8x8 register file. A START pulse in IDLE
//   reads the file two registers at a time (2k on port 1, 2k+1 on port 2),
//   snapshots both bytes, then streams them out in register order over a
//   VALID/READY byte handshake tagged with the register index.
// Ports
//   CLK    : clock, all state on the rising edge
//   RESET  : synchronous, active-high; wins over everything, abandons a dump
//   START  : dump request, only looked at in IDLE
//   BUSY   : high while the reader owns the register-file read ports
//   DONE   : one-cycle pulse after the last byte is accepted
//   bus    : read-port + byte-stream bundle (reg_dump_reader_if.master)
module reg_dump_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int NUM_REGS   = 8
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                START,
  output logic                BUSY,
  output logic                DONE,
  reg_dump_reader_if.master   bus
);

  localparam int KW = ADDR_WIDTH - 1;
  localparam logic [KW-1:0] LAST_K = KW'(NUM_REGS / 2 - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ADDR    = 3'd1;
  localparam logic [2:0] S_SAMPLE  = 3'd2;
  localparam logic [2:0] S_SEND_LO = 3'd3;
  localparam logic [2:0] S_SEND_HI = 3'd4;
  localparam logic [2:0] S_FIN     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [KW-1:0]         k_q, k_d;
  logic [DATA_WIDTH-1:0] buf_lo_q, buf_lo_d;
  logic [DATA_WIDTH-1:0] buf_hi_q, buf_hi_d;
  logic                  accept;

  assign accept = bus.DOUT_VALID && bus.DOUT_READY;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    buf_lo_d = buf_lo_q;
    buf_hi_d = buf_hi_q;
    case (state_q)
      S_IDLE: if (START) begin
        state_d = S_ADDR;
        k_d     = '0;
      end
      // Addresses were already presented this cycle; give the async read a
      // full period before sampling.
      S_ADDR:   state_d = S_SAMPLE;
      S_SAMPLE: begin
        buf_lo_d = bus.RD_DATA1;
        buf_hi_d = bus.RD_DATA2;
        state_d  = S_SEND_LO;
      end
      S_SEND_LO: if (accept) state_d = S_SEND_HI;
      S_SEND_HI: if (accept) begin
        if (k_q == LAST_K) begin
          // Park k at 0 so the read ports idle at 0/1 like after reset.
          k_d     = '0;
          state_d = S_FIN;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = S_ADDR;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      buf_lo_q <= '0;
      buf_hi_q <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      buf_lo_q <= buf_lo_d;
      buf_hi_q <= buf_hi_d;
    end
  end

  // Outputs are pure decodes of flop state, so they only move after an edge
  // and stay put while a byte waits for READY.
  assign bus.RD_ADDR1   = {k_q, 1'b0};
  assign bus.RD_ADDR2   = {k_q, 1'b1};
  assign bus.DOUT_VALID = (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
  assign bus.DOUT_IDX   = {k_q, (state_q == S_SEND_HI)};
  assign bus.DOUT       = (state_q == S_SEND_HI) ? buf_hi_q :
                          (state_q == S_SEND_LO) ? buf_lo_q : '0;
  assign BUSY = (state_q == S_ADDR) || (state_q == S_SAMPLE) ||
                (state_q == S_SEND_LO) || (state_q == S_SEND_HI);
  assign DONE = (state_q == S_FIN);

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;
  logic CLK = 1'b0;
  logic RESET = 1'b0;
  logic START = 1'b0;
  logic BUSY, DONE;

  reg_dump_reader_if bus ();

  reg_dump_reader dut (
    .CLK   (CLK),
    .RESET (RESET),
    .START (START),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // register file model: synchronous write / reset, asynchronous read
  logic [7:0] rf [8];
  logic       rf_rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [7:0] wr_data = '0;

  always @(posedge CLK) begin
    if (rf_rst) for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
    else if (wr_en) rf[wr_addr] <= wr_data;
  end
  assign bus.RD_DATA1 = rf[bus.RD_ADDR1];
  assign bus.RD_DATA2 = rf[bus.RD_ADDR2];

  // reference: what the register file should hold
  logic [7:0] model [8];

  typedef struct packed { logic [2:0] idx; logic [7:0] data; } item_t;
  item_t sc_q[$];

  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int ready_mode = 0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // READY driver: 0 always ready, 1 random, 2 stall IDX 3 for 3 cycles,
  // 3 hold IDX 4 pending indefinitely
  always @(posedge CLK) begin
    #1;
    if (!BUSY) stall_cnt = 0;
    case (ready_mode)
      0: bus.DOUT_READY = 1'b1;
      1: bus.DOUT_READY = ($urandom_range(0, 2) != 0);
      2: if (bus.DOUT_VALID && bus.DOUT_IDX == 3'd3 && stall_cnt < 3) begin
           bus.DOUT_READY = 1'b0;
           stall_cnt++;
         end else bus.DOUT_READY = 1'b1;
      default: bus.DOUT_READY = !(bus.DOUT_VALID && bus.DOUT_IDX == 3'd4);
    endcase
  end

  // monitor: pops the scoreboard on every accepted byte, checks hold rules
  logic  pend = 1'b0;
  item_t pend_it;
  always @(negedge CLK) begin
    if (DONE) done_cnt++;
    if (RESET) pend = 1'b0;
    else begin
      if (pend) begin
        chk("hold_valid", 32'(bus.DOUT_VALID), 1);
        chk("hold_idx_data", {bus.DOUT_IDX, bus.DOUT}, {pend_it.idx, pend_it.data});
      end
      pend = 1'b0;
      if (bus.DOUT_VALID) begin
        if (!bus.DOUT_READY) begin
          pend = 1'b1;
          pend_it.idx = bus.DOUT_IDX;
          pend_it.data = bus.DOUT;
        end else if (sc_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_byte: got idx %0d data %0h, expected no byte",
                   bus.DOUT_IDX, bus.DOUT);
        end else begin
          item_t e;
          e = sc_q.pop_front();
          chk("stream_idx", 32'(bus.DOUT_IDX), 32'(e.idx));
          chk("stream_data", 32'(bus.DOUT), 32'(e.data));
        end
      end
    end
  end

  task automatic rf_write(input logic [2:0] a, input logic [7:0] d);
    @(posedge CLK) #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model[a] = d;
    @(posedge CLK) #1;
    wr_en = 1'b0;
  endtask

  // START is raised alongside RESET: it must be ignored
  task automatic do_reset(input bit with_rf);
    @(posedge CLK) #1;
    RESET = 1'b1; START = 1'b1; rf_rst = with_rf;
    @(posedge CLK) #1;
    RESET = 1'b0; START = 1'b0; rf_rst = 1'b0;
    if (with_rf) for (int i = 0; i < 8; i++) model[i] = 8'h00;
  endtask

  task automatic chk_reset_state();
    chk("rst_addr1", 32'(bus.RD_ADDR1), 0);
    chk("rst_addr2", 32'(bus.RD_ADDR2), 1);
    chk("rst_dout", 32'(bus.DOUT), 0);
    chk("rst_idx", 32'(bus.DOUT_IDX), 0);
    chk("rst_valid", 32'(bus.DOUT_VALID), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_done", 32'(DONE), 0);
  endtask

  // hooks: 1 = concurrent writes during pair 0, 2 = extra START pulses
  task automatic run_dump(input logic [7:0] exp [8], input int exp_cyc, input int hooks);
    int n;
    int d0;
    bit prev_busy;
    n = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 8; i++) sc_q.push_back({3'(i), exp[i]});
    d0 = done_cnt;
    @(posedge CLK) #1;
    START = 1'b1;
    while (!DONE && n < 300) begin
      prev_busy = BUSY;
      @(posedge CLK) #1;
      n++;
      if (n == 1) START = 1'b0;
      if (hooks == 1) begin
        // n==3: pair 0 already sampled; write R1 (must not show)
        if (n == 3) begin wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'h55; end
        // n==4: R6 written long before pair 3 is sampled (must show)
        if (n == 4) begin wr_addr = 3'd6; wr_data = 8'hAA; end
        if (n == 5) wr_en = 1'b0;
      end
      if (hooks == 2) START = (n == 6 || n == 10 || n == 14);
    end
    START = 1'b0;
    if (!DONE) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no DONE in %0d cycles, expected DONE", n);
    end else begin
      if (exp_cyc > 0) chk("done_latency", n, exp_cyc);
      else chk("done_latency_min", 32'(n >= 17), 1);
      chk("busy_before_done", 32'(prev_busy), 1);
    end
    chk("busy_with_done", 32'(BUSY), 0);
    @(posedge CLK) #1;
    chk("done_pulse_width", 32'(DONE), 0);
    chk("queue_drained", sc_q.size(), 0);
    chk("done_count", done_cnt - d0, 1);
    sc_q.delete();
  endtask

  initial begin
    logic [7:0] exp [8];
    int n;

    // preload R0..R7 = 0x10..0x17, then reset with a simultaneous START
    for (int i = 0; i < 8; i++) rf_write(3'(i), 8'h10 + 8'(i));
    do_reset(1'b0);
    chk_reset_state();
    @(posedge CLK) #1;
    chk("start_with_reset_ignored", 32'(BUSY), 0);

    // full dump, READY high
    ready_mode = 0;
    run_dump(model, 17, 0);

    // backpressure on IDX 3
    ready_mode = 2;
    run_dump(model, 20, 0);

    // reset while IDX 4 is pending
    ready_mode = 3;
    for (int i = 0; i < 8; i++) sc_q.push_back({3'(i), model[i]});
    @(posedge CLK) #1;
    START = 1'b1;
    @(posedge CLK) #1;
    START = 1'b0;
    n = 0;
    while (!(bus.DOUT_VALID && bus.DOUT_IDX == 3'd4) && n < 100) begin
      @(posedge CLK) #1;
      n++;
    end
    chk("reach_idx4", 32'(bus.DOUT_VALID && bus.DOUT_IDX == 3'd4), 1);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK) #1;
    RESET = 1'b0;
    chk("midrst_valid", 32'(bus.DOUT_VALID), 0);
    chk("midrst_busy", 32'(BUSY), 0);
    chk("midrst_addr1", 32'(bus.RD_ADDR1), 0);
    chk("midrst_addr2", 32'(bus.RD_ADDR2), 1);
    chk("midrst_bytes_left", sc_q.size(), 4);
    sc_q.delete();
    ready_mode = 0;
    run_dump(model, 17, 0);

    // extra STARTs while busy
    run_dump(model, 17, 2);

    // concurrent writes: R6 shows, R1 does not
    for (int i = 0; i < 8; i++) exp[i] = model[i];
    exp[6] = 8'hAA;
    run_dump(exp, 17, 1);
    model[1] = 8'h55;
    model[6] = 8'hAA;
    run_dump(model, 17, 0);

    // random contents and random READY
    ready_mode = 1;
    repeat (4) begin
      for (int i = 0; i < 8; i++) rf_write(3'(i), 8'($urandom));
      run_dump(model, 0, 0);
    end

    // reset register file and reader together: all zeros
    ready_mode = 0;
    do_reset(1'b1);
    chk_reset_state();
    run_dump(model, 17, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
